// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter feeding a shared 4-bit ALU, with a registered, ID-tagged response.
// Optional ALU_ARB_ILLEGAL_OP_ERR_EN adds the rsp_err output, which flags opcodes 110/111.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,

    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_id
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
    ,
    output logic       rsp_err
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e     state_q;
    logic       last_grant_q;
    logic [3:0] op_a_q;
    logic [3:0] op_b_q;
    logic [2:0] op_sel_q;
    logic       op_id_q;

    logic       grant0;
    logic       grant1;

    function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] sel);
        logic [3:0] res;
        res = 4'b0000;
        case (sel)
            3'b000:  res = a + b;
            3'b001:  res = a - b;
            3'b010:  res = a & b;
            3'b011:  res = a | b;
            3'b100:  res = a ^ b;
            3'b101:  res = {3'b000, (a < b)};
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    // A lone requester always wins; on contention the one not granted last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_grant_q);
        grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end

    assign req0_ready = (state_q == StIdle) && grant0;
    assign req1_ready = (state_q == StIdle) && grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_a_q       <= 4'd0;
            op_b_q       <= 4'd0;
            op_sel_q     <= 3'd0;
            op_id_q      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_result   <= 4'd0;
            rsp_id       <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0_ready) begin
                        op_a_q       <= req0_a;
                        op_b_q       <= req0_b;
                        op_sel_q     <= req0_sel;
                        op_id_q      <= 1'b0;
                        last_grant_q <= 1'b0;
                        state_q      <= StExec;
                    end else if (req1_ready) begin
                        op_a_q       <= req1_a;
                        op_b_q       <= req1_b;
                        op_sel_q     <= req1_sel;
                        op_id_q      <= 1'b1;
                        last_grant_q <= 1'b1;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    rsp_result <= alu_fn(op_a_q, op_b_q, op_sel_q);
                    rsp_id     <= op_id_q;
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
                    rsp_err    <= (op_sel_q[2:1] == 2'b11);
`endif
                    rsp_valid  <= 1'b1;
                    state_q    <= StResp;
                end
                StResp: begin
                    // Response payload is held untouched until the consumer takes it.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
